// File: rtl/sudoku_button_conditioner.sv
// sudoku_button_conditioner
// Conditions the raw Prev/Next/Enter/Start buttons for the Sudoku solver core.
// Every button gets a two-flop synchronizer and its own debounce FSM, and the
// block produces a debounced level (Dpb), a single-clock press pulse (Scen)
// and a press-plus-auto-repeat pulse (Mcen).
//
// Optional feature macro: SUDOKU_BTN_MCEN_EN
//   defined   -> holding a button produces periodic auto-repeat pulses on Mcen
//   undefined -> Mcen is identical to Scen (one pulse per press, no repeat)

module sudoku_button_conditioner #(
    parameter int N_BTN     = 4,
    parameter int WAIT_BITS = 20,
    parameter int HOLD_BITS = 25
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] BtnIn,
    output logic [N_BTN-1:0] Dpb,
    output logic [N_BTN-1:0] Scen,
    output logic [N_BTN-1:0] Mcen
);

    // One counter per button is shared by the press, hold and release phases,
    // so it must be wide enough for the longest of the windows.
    localparam int CNT_BITS = (WAIT_BITS > HOLD_BITS) ? WAIT_BITS : HOLD_BITS;

    // Terminal count of the quiet window used for both press and release.
    localparam logic [CNT_BITS-1:0] WAIT_MAX = CNT_BITS'({WAIT_BITS{1'b1}});

`ifdef SUDOKU_BTN_MCEN_EN
    // Terminal count of the hold window between auto-repeat pulses.
    localparam logic [CNT_BITS-1:0] HOLD_MAX = CNT_BITS'({HOLD_BITS{1'b1}});
`endif

    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

    // One-hot debounce states; outputs are decoded straight from these bits.
`ifdef SUDOKU_BTN_MCEN_EN
    typedef enum logic [5:0] {
        ST_INI  = 6'b000001,
        ST_WQ   = 6'b000010,
        ST_SCEN = 6'b000100,
        ST_HOLD = 6'b001000,
        ST_MCEN = 6'b010000,
        ST_CCR  = 6'b100000
    } btnState_t;
`else
    typedef enum logic [4:0] {
        ST_INI  = 5'b00001,
        ST_WQ   = 5'b00010,
        ST_SCEN = 5'b00100,
        ST_HOLD = 5'b01000,
        ST_CCR  = 5'b10000
    } btnState_t;
`endif

    logic [N_BTN-1:0] syncOneQ;
    logic [N_BTN-1:0] syncTwoQ;

    // Two-flop synchronizer bringing the asynchronous button levels into Clk.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            syncOneQ <= '0;
            syncTwoQ <= '0;
        end else begin
            syncOneQ <= BtnIn;
            syncTwoQ <= syncOneQ;
        end
    end

    // Each button owns an independent FSM and counter; buttons never interact.
    for (genvar b = 0; b < N_BTN; b++) begin : gBtn

        btnState_t           stateQ;
        btnState_t           stateD;
        logic [CNT_BITS-1:0] cntQ;
        logic [CNT_BITS-1:0] cntD;
        logic                btnLevel;
        logic                pressHit;
        logic                repeatHit;

        assign btnLevel = syncTwoQ[b];

        // State and counter registers, cleared to idle by reset at any time.
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                stateQ <= ST_INI;
                cntQ   <= CNT_ZERO;
            end else begin
                stateQ <= stateD;
                cntQ   <= cntD;
            end
        end

        // Next-state logic; the counter restarts from zero on every state entry.
        always_comb begin
            stateD = stateQ;
            cntD   = cntQ;
            case (stateQ)
                ST_INI: begin
                    cntD = CNT_ZERO;
                    if (btnLevel) begin
                        stateD = ST_WQ;
                    end
                end

                ST_WQ: begin
                    if (!btnLevel) begin
                        stateD = ST_INI;
                        cntD   = CNT_ZERO;
                    end else if (cntQ == WAIT_MAX) begin
                        stateD = ST_SCEN;
                        cntD   = CNT_ZERO;
                    end else begin
                        cntD = cntQ + CNT_ONE;
                    end
                end

                ST_SCEN: begin
                    stateD = ST_HOLD;
                    cntD   = CNT_ZERO;
                end

`ifdef SUDOKU_BTN_MCEN_EN
                ST_HOLD: begin
                    if (!btnLevel) begin
                        stateD = ST_CCR;
                        cntD   = CNT_ZERO;
                    end else if (cntQ == HOLD_MAX) begin
                        stateD = ST_MCEN;
                        cntD   = CNT_ZERO;
                    end else begin
                        cntD = cntQ + CNT_ONE;
                    end
                end

                ST_MCEN: begin
                    stateD = ST_HOLD;
                    cntD   = CNT_ZERO;
                end
`else
                ST_HOLD: begin
                    cntD = CNT_ZERO;
                    if (!btnLevel) begin
                        stateD = ST_CCR;
                    end
                end
`endif

                ST_CCR: begin
                    if (btnLevel) begin
                        stateD = ST_HOLD;
                        cntD   = CNT_ZERO;
                    end else if (cntQ == WAIT_MAX) begin
                        stateD = ST_INI;
                        cntD   = CNT_ZERO;
                    end else begin
                        cntD = cntQ + CNT_ONE;
                    end
                end

                default: begin
                    stateD = ST_INI;
                    cntD   = CNT_ZERO;
                end
            endcase
        end

        assign pressHit = (stateQ == ST_SCEN);

`ifdef SUDOKU_BTN_MCEN_EN
        assign repeatHit = (stateQ == ST_MCEN);
`else
        assign repeatHit = 1'b0;
`endif

        assign Scen[b] = pressHit;
        assign Mcen[b] = pressHit | repeatHit;
        assign Dpb[b]  = pressHit | repeatHit | (stateQ == ST_HOLD) | (stateQ == ST_CCR);

    end : gBtn

endmodule

// File: tb/tb_sudoku_button_conditioner.sv
// tb_sudoku_button_conditioner
// Directed bench for sudoku_button_conditioner with WAIT_BITS=2, HOLD_BITS=3.
// Expected values are hand-derived edge by edge; edge 0 is the first clock
// edge that samples the new button level. Outputs are sampled 1 ns after the
// rising edge, so a value observed after edge k is the value during the cycle
// following edge k. Auto-repeat expectations follow SUDOKU_BTN_MCEN_EN.

`timescale 1ns/1ps

module tb_sudoku_button_conditioner;

    logic       Clk;
    logic       Reset;
    logic [3:0] BtnIn;
    logic [3:0] Dpb;
    logic [3:0] Scen;
    logic [3:0] Mcen;

    int checkCount;
    int passCount;

    sudoku_button_conditioner #(
        .N_BTN     (4),
        .WAIT_BITS (2),
        .HOLD_BITS (3)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .BtnIn (BtnIn),
        .Dpb   (Dpb),
        .Scen  (Scen),
        .Mcen  (Mcen)
    );

    // Free-running 100 MHz clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [11:0] observed();
        return {Dpb, Scen, Mcen};
    endfunction

    function automatic logic [11:0] pack(input logic [3:0] d, input logic [3:0] s, input logic [3:0] m);
        return {d, s, m};
    endfunction

    task automatic applyStimulus(input logic [3:0] btn);
        BtnIn = btn;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] want);
        checkCount++;
        if (got !== want) begin
            $display("[TB] FAIL %s: got {Dpb,Scen,Mcen}=%b required %b", tag, got, want);
        end else begin
            passCount++;
        end
    endtask

    // Directed scenarios run back to back, each starting from the idle state.
    initial begin
        logic [3:0] expD;
        logic [3:0] expS;
        logic [3:0] expM;

        checkCount = 0;
        passCount  = 0;
        Reset      = 1'b0;
        applyStimulus(4'b0000);

        repeat (3) tick();
        checkOutput("reset", observed(), 12'h000);
        Reset = 1'b1;
        repeat (3) tick();
        checkOutput("idle after reset", observed(), 12'h000);

        // Clean press on Next: pulse after edge 6, level from edge 6.
        applyStimulus(4'b0010);
        for (int e = 0; e < 10; e++) begin
            tick();
            expD = (e >= 6) ? 4'b0010 : 4'b0000;
            expS = (e == 6) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("clean press e%0d", e), observed(), pack(expD, expS, expS));
        end

        // Clean release: Dpb drops at release edge + 6.
        applyStimulus(4'b0000);
        for (int r = 0; r < 8; r++) begin
            tick();
            expD = (r < 6) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("clean release r%0d", r), observed(), pack(expD, 4'b0000, 4'b0000));
        end

        // Press bounce on Enter: 1,1,0,0 then held; final rising sample is edge 4.
        for (int e = 0; e < 15; e++) begin
            applyStimulus((e == 2 || e == 3) ? 4'b0000 : 4'b0100);
            tick();
            expD = (e >= 10) ? 4'b0100 : 4'b0000;
            expS = (e == 10) ? 4'b0100 : 4'b0000;
            checkOutput($sformatf("bounce e%0d", e), observed(), pack(expD, expS, expS));
        end
        applyStimulus(4'b0000);
        repeat (10) tick();
        checkOutput("idle after bounce", observed(), 12'h000);

        // Long hold on Prev for 40 edges.
        applyStimulus(4'b0001);
        for (int e = 0; e < 40; e++) begin
            tick();
            expD = (e >= 6) ? 4'b0001 : 4'b0000;
            expS = (e == 6) ? 4'b0001 : 4'b0000;
`ifdef SUDOKU_BTN_MCEN_EN
            expM = (e == 6 || e == 15 || e == 24 || e == 33) ? 4'b0001 : 4'b0000;
`else
            expM = (e == 6) ? 4'b0001 : 4'b0000;
`endif
            checkOutput($sformatf("hold e%0d", e), observed(), pack(expD, expS, expM));
        end

        // Release after the hold.
        applyStimulus(4'b0000);
        for (int r = 0; r < 8; r++) begin
            tick();
            expD = (r < 6) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("hold release r%0d", r), observed(), pack(expD, 4'b0000, 4'b0000));
        end
        repeat (2) tick();

        // Release with a one-cycle re-press glitch at edge 13 (release edge 10).
        for (int e = 0; e < 23; e++) begin
            applyStimulus((e < 10 || e == 13) ? 4'b0001 : 4'b0000);
            tick();
            expD = (e >= 6 && e < 20) ? 4'b0001 : 4'b0000;
            expS = (e == 6) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("release glitch e%0d", e), observed(), pack(expD, expS, expS));
        end
        repeat (2) tick();

        // Reset mid-press: Next reaches HOLD, Start is still in its quiet window.
        for (int e = 0; e < 11; e++) begin
            applyStimulus((e >= 7) ? 4'b1010 : 4'b0010);
            tick();
            expD = (e >= 6) ? 4'b0010 : 4'b0000;
            expS = (e == 6) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("pre-reset e%0d", e), observed(), pack(expD, expS, expS));
        end
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("async reset", observed(), 12'h000);
        applyStimulus(4'b1000);
        repeat (2) tick();
        checkOutput("held in reset", observed(), 12'h000);
        Reset = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            expD = (e >= 6) ? 4'b1000 : 4'b0000;
            expS = (e == 6) ? 4'b1000 : 4'b0000;
            checkOutput($sformatf("post-reset press e%0d", e), observed(), pack(expD, expS, expS));
        end

        applyStimulus(4'b0000);
        repeat (10) tick();
        checkOutput("final idle", observed(), 12'h000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
